perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised performance-statistics unit for the pipelined CPU, succeeding the fixed cycle, branch and bubble counters. It provides NUM_CH independent event counters, gated by a halt/go run-control state machine, with a snapshot shadow bank for glitch-free readout. A registered read mux drives the LED/segment display.

## Interface
- NUM_CH, 4: number of event channels. Channel 0 is wired to a constant 1 at top level, so it counts total cycles.
- CNT_W, 32: counter width in bits.
- SEL_W, 2: width of rd_sel. Requires 2^SEL_W ≥ NUM_CH.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- halt  input  1  CPU paused (syscall halt), level.
- go  input  1  resume request from the debounced button, level. Only its rising edge acts.
- event  input  NUM_CH  per-cycle event strobes; bit i means count one event on channel i.
- clr  input  1  synchronous clear of live counters and overflow flags.
- snap  input  1  capture all live counters into the shadow bank.
- rd_sel  input  SEL_W  shadow channel to display.
- rd_data  output  CNT_W  registered shadow value of channel rd_sel.
- ovf  output  NUM_CH  sticky per-channel overflow flags.
- running  output  1  high when counting is enabled (state is not HALT).

## Operation
- FSM states:
  - RUN: counting enabled.
  - HALT: counting frozen.
  - RESUME: one-cycle grace state; counts and ignores halt.
- Transitions:
  - RUN → HALT when halt=1.
  - HALT → RESUME on a go rising edge. The edge is detected internally as go & ~go_q, where go_q is a register.
  - RESUME → RUN unconditionally.
  - All other cases hold the current state.
- Counting: cnt[i] increments by 1 on a clock edge when the state is RUN or RESUME and event[i]=1.
  - The cycle in which halt is first sampled is still counted, because the state is still RUN.
  - Counting stops from the following cycle.
- Arithmetic: unsigned, CNT_W bits. On the increment from all-ones, ovf[i] is set. ovf[i] stays set until clr or rst.
- clr: zeroes every cnt and ovf on the next edge.
  - clr has priority over a same-cycle event.
  - clr does not clear the shadow bank or change the FSM state.
- snap: shadow[i] ← cnt[i] for all i on the next edge. Capture uses the pre-increment value of that cycle, so an event in the snap cycle is not included.
- snap and clr in the same cycle: the shadow captures the old values and the live counters clear. This gives an atomic read-and-reset.
- Read path: rd_data ← shadow[rd_sel] on every edge. If rd_sel ≥ NUM_CH, rd_data ← 0.
- go edge while in RUN or RESUME: ignored. The go_q register still updates.

## Timing
- Reset values: state=RUN, every cnt=0, every shadow=0, ovf=0, go_q=0, rd_data=0, running=1.
- Event to counter: 1 cycle.
- Counter to snap to rd_data: 2 cycles from snap assertion. The shadow updates at edge 1 and rd_data at edge 2.
- rd_sel to rd_data: 1 cycle.
- halt to running low: 1 cycle.
- go edge to running high: 1 cycle (HALT → RESUME).
- rst asserted mid-count or while in HALT overrides everything, including the FSM, on that edge.
- No combinational path from inputs to outputs. running decodes the state register only.

## Configuration
- PERF_SATURATE_EN defined: counters saturate. A counter at all-ones holds at all-ones, and ovf[i] still sets on the first attempted increment past it.
- PERF_SATURATE_EN undefined (default): counters wrap to 0, and ovf[i] sets on the wrap.

## Test plan
- Reset and free-run:
  - Stimulus: rst for 2 cycles, event=4'b0001, 10 cycles, then snap, rd_sel=0.
  - Required: rd_data=10 two cycles after snap; running=1 throughout.
- Halt/go:
  - Stimulus: halt=1 at cycle 5 and held; go pulsed high at cycle 20 for 3 cycles; halt dropped at cycle 21; count channel 0.
  - Required: cnt[0]=6 frozen through the halt. running=0 during cycles 6–20. Exactly one resume (a held go gives no repeat). Counting resumes from cycle 21.
- Snap/clr atomicity:
  - Stimulus: cnt[1]=7 with event[1]=1; assert snap and clr in the same cycle; rd_sel=1.
  - Required: rd_data=7, cnt[1]=0, ovf=0.
- Wrap or saturate:
  - Stimulus: CNT_W=4, channel 2 driven to 15, then one more event.
  - Required without PERF_SATURATE_EN: cnt=0, ovf[2]=1.
  - Required with PERF_SATURATE_EN: cnt=15, ovf[2]=1.
- Out-of-range select:
  - Stimulus: NUM_CH=3, SEL_W=2, rd_sel=3.
  - Required: rd_data=0.
- Reset mid-halt:
  - Stimulus: in HALT with cnt[0]=42, assert rst.
  - Required: next cycle state=RUN, running=1, cnt[0]=0, rd_data=0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance counter bank: NUM_CH event counters gated by a RUN/HALT/RESUME run-control FSM,
// with a snapshot shadow bank and a registered read mux. Define PERF_SATURATE_EN for saturating counters.
module perf_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_i,
  input  logic              go_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              clr_i,
  input  logic              snap_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              running_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    RESUME = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              go_q;
  logic              count_en;
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_i) state_d = HALT;
      HALT:    if (go_i && !go_q) state_d = RESUME;
      RESUME:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // RESUME still counts, so only HALT freezes the counters.
  assign count_en = (state_q != HALT);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      ovf_d[i]    = ovf_q[i];
      shadow_d[i] = snap_i ? cnt_q[i] : shadow_q[i];
      if (clr_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (count_en && event_i[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Selects beyond NUM_CH fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      go_q      <= 1'b0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      go_q      <= go_i;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign ovf_o     = ovf_q;
  assign running_o = (state_q != HALT);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a default-size instance tracked by a reference model, plus a
// small 3-channel 4-bit instance driven from a vector table for wrap/saturate and select corners.
module tb_perf_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, go, clr, snap;
  logic [3:0]  ev;
  logic [1:0]  sel;
  logic [31:0] rdData;
  logic [3:0]  ovf;
  logic        running;

  logic        halt2, go2, clr2, snap2;
  logic [2:0]  ev2;
  logic [1:0]  sel2;
  logic [3:0]  rdData2;
  logic [2:0]  ovf2;
  logic        running2;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SEL_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .go_i(go), .event_i(ev),
    .clr_i(clr), .snap_i(snap), .rd_sel_i(sel),
    .rd_data_o(rdData), .ovf_o(ovf), .running_o(running)
  );

  perf_counter_bank #(.NUM_CH(3), .CNT_W(4), .SEL_W(2)) dutSmall (
    .clk_i(clk), .rst_i(rst), .halt_i(halt2), .go_i(go2), .event_i(ev2),
    .clr_i(clr2), .snap_i(snap2), .rd_sel_i(sel2),
    .rd_data_o(rdData2), .ovf_o(ovf2), .running_o(running2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of the default instance: counts, shadow copies and a halted/grace view of run control.
  logic [31:0] mCnt    [4];
  logic [31:0] mShadow [4];
  logic [3:0]  mOvf;
  logic [31:0] mRd;
  bit          mHalted, mGrace, mGoPrev;

`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
  localparam logic [3:0] AFTER_TOP = 4'd15;
`else
  localparam bit SAT = 1'b0;
  localparam logic [3:0] AFTER_TOP = 4'd0;
`endif

  typedef struct {
    int         reps;
    logic [2:0] ev;
    logic       clr;
    logic       snap;
    logic [1:0] sel;
    logic [3:0] expRd;
    logic [2:0] expOvf;
  } vec_t;

  vec_t tbl [14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelStep();
    bit counting;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mCnt[i]    = 32'd0;
        mShadow[i] = 32'd0;
      end
      mOvf = 4'd0; mRd = 32'd0;
      mHalted = 1'b0; mGrace = 1'b0; mGoPrev = 1'b0;
      return;
    end
    mRd = mShadow[sel];
    if (snap) for (int i = 0; i < 4; i++) mShadow[i] = mCnt[i];
    counting = !mHalted;
    for (int i = 0; i < 4; i++) begin
      if (clr) begin
        mCnt[i] = 32'd0;
        mOvf[i] = 1'b0;
      end else if (counting && ev[i]) begin
        if (mCnt[i] == 32'hFFFF_FFFF) begin
          mOvf[i] = 1'b1;
          if (!SAT) mCnt[i] = 32'd0;
        end else begin
          mCnt[i] = mCnt[i] + 32'd1;
        end
      end
    end
    if (mGrace) mGrace = 1'b0;
    else if (!mHalted) begin
      if (halt) mHalted = 1'b1;
    end else if (go && !mGoPrev) begin
      mHalted = 1'b0;
      mGrace  = 1'b1;
    end
    mGoPrev = go;
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic g, input logic [3:0] e,
                               input logic c, input logic s, input logic [1:0] rs);
    rst = r; halt = h; go = g; ev = e; clr = c; snap = s; sel = rs;
    @(posedge clk);
    #1;
    modelStep();
    checkOutput("model rd_data", rdData, mRd);
    checkOutput("model ovf", 32'(ovf), 32'(mOvf));
    checkOutput("model running", 32'(running), 32'(!mHalted));
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; go = 1'b0; ev = 4'd0; clr = 1'b0; snap = 1'b0; sel = 2'd0;
    halt2 = 1'b0; go2 = 1'b0; clr2 = 1'b0; snap2 = 1'b0; ev2 = 3'd0; sel2 = 2'd0;

    tbl[0]  = '{15, 3'b100, 1'b0, 1'b0, 2'd2, 4'd0,      3'b000};
    tbl[1]  = '{1,  3'b000, 1'b0, 1'b1, 2'd2, 4'd0,      3'b000};
    tbl[2]  = '{1,  3'b000, 1'b0, 1'b0, 2'd2, 4'd15,     3'b000};
    tbl[3]  = '{1,  3'b100, 1'b0, 1'b0, 2'd2, 4'd15,     3'b100};
    tbl[4]  = '{1,  3'b000, 1'b0, 1'b1, 2'd2, 4'd15,     3'b100};
    tbl[5]  = '{1,  3'b000, 1'b0, 1'b0, 2'd2, AFTER_TOP, 3'b100};
    tbl[6]  = '{1,  3'b000, 1'b0, 1'b0, 2'd3, 4'd0,      3'b100};
    tbl[7]  = '{3,  3'b001, 1'b0, 1'b0, 2'd3, 4'd0,      3'b100};
    tbl[8]  = '{1,  3'b011, 1'b1, 1'b1, 2'd0, 4'd0,      3'b000};
    tbl[9]  = '{1,  3'b000, 1'b0, 1'b0, 2'd0, 4'd3,      3'b000};
    tbl[10] = '{1,  3'b000, 1'b0, 1'b0, 2'd2, AFTER_TOP, 3'b000};
    tbl[11] = '{1,  3'b000, 1'b0, 1'b1, 2'd0, 4'd3,      3'b000};
    tbl[12] = '{1,  3'b000, 1'b0, 1'b0, 2'd0, 4'd0,      3'b000};
    tbl[13] = '{1,  3'b000, 1'b0, 1'b0, 2'd3, 4'd0,      3'b000};

    // Reset and free-run on channel 0
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    checkOutput("reset running", 32'(running), 32'd1);
    checkOutput("reset rd_data", rdData, 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    checkOutput("small reset rd_data", 32'(rdData2), 32'd0);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0);
    checkOutput("freerun running", 32'(running), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    checkOutput("freerun rd_data", rdData, 32'd10);

    // Small instance: wrap/saturate, out-of-range select, snap+clr
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        ev2 = tbl[r].ev; clr2 = tbl[r].clr; snap2 = tbl[r].snap; sel2 = tbl[r].sel;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        checkOutput($sformatf("tbl%0d rd_data", r), 32'(rdData2), 32'(tbl[r].expRd));
        checkOutput($sformatf("tbl%0d ovf", r), 32'(ovf2), 32'(tbl[r].expOvf));
        checkOutput($sformatf("tbl%0d running", r), 32'(running2), 32'd1);
      end
    end
    ev2 = 3'd0; clr2 = 1'b0; snap2 = 1'b0; sel2 = 2'd0;

    // Halt/go, then a go rising while running followed by a halt with go still held
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 36; c++) begin
      logic h, g, s;
      h = (c >= 5 && c < 21) || (c >= 31);
      g = (c >= 20 && c < 23) || (c >= 30);
      s = (c == 15) || (c == 28);
      applyStimulus(1'b0, h, g, 4'b0001, 1'b0, s, 2'd0);
      checkOutput($sformatf("halt/go running c%0d", c), 32'(running),
                  32'(!((c >= 5 && c <= 19) || (c >= 31))));
      if (c == 16) checkOutput("halt frozen count", rdData, 32'd6);
      if (c == 29) checkOutput("resumed count", rdData, 32'd13);
    end

    // Atomic snap and clear
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 7; c++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
    checkOutput("snapclr rd_data", rdData, 32'd7);
    checkOutput("snapclr ovf", 32'(ovf), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
    checkOutput("snapclr cleared cnt", rdData, 32'd0);

    // Reset while halted
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 41; c++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    checkOutput("halted count", rdData, 32'd42);
    checkOutput("halted running", 32'(running), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    checkOutput("rst-in-halt running", 32'(running), 32'd1);
    checkOutput("rst-in-halt rd_data", rdData, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    checkOutput("rst-in-halt cnt", rdData, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
